// File: rtl/control_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, ALUOp codes,
// datapath select codes, FSM state encoding and the packed control word.
package control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // ALUControl also decodes these, so the values must stay in sync with it
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTEXEC, RTWB, ADDIEXEC, ADDIWB, BRANCH, JUMP
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] data_uc;
  } ctrl_t;

  function automatic logic is_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit to datapath bundle: the latched opcode and memory ready come in,
// every enable/select and the ALUOp code go out.
interface multicycle_control_unit_if;
  logic [5:0] Opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic [2:0] dataUC;
  logic       illegal_op;

  modport master (
    input  Opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, dataUC, illegal_op
  );

  modport slave (
    output Opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, dataUC, illegal_op
  );
endinterface

// File: rtl/control_output_decoder.sv
// Combinational map from FSM state (plus qualified mem_ready in FETCH) to the
// datapath control word.
module control_output_decoder
  import control_pkg::*;
(
  input  state_t state,
  input  logic   mem_ok,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.data_uc   = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // IR and PC must only load on the cycle the fetch actually completes
        ctrl.ir_write  = mem_ok;
        ctrl.pc_write  = mem_ok;
      end
      DECODE: begin
        ctrl.alu_src_b = SRCB_IMMSH2;
        ctrl.data_uc   = ALUOP_ADD;
      end
      MEMADR, ADDIEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.data_uc   = ALUOP_ADD;
      end
      MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      RTEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.data_uc   = ALUOP_FUNCT;
      end
      RTWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      ADDIWB: ctrl.reg_write = 1'b1;
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.data_uc       = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Main multicycle MIPS control FSM: state register, opcode-driven next-state
// logic and the sticky illegal-opcode flag; outputs come from the decoder.
module multicycle_control_unit
  import control_pkg::*;
#(
  parameter bit USE_MEM_READY = 1'b1
) (
  input logic                    clk,
  input logic                    rst_n,
  multicycle_control_unit_if.master bus
);

  state_t state, next_state;
  ctrl_t  ctrl;
  logic   mem_ok;
  logic   illegal_q;

  assign mem_ok = USE_MEM_READY ? bus.mem_ready : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:   next_state = FETCH;
      FETCH:  if (mem_ok) next_state = DECODE;
      DECODE: begin
        unique case (bus.Opcode)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = RTEXEC;
          OP_ADDI:      next_state = ADDIEXEC;
          OP_BEQ:       next_state = BRANCH;
          OP_J:         next_state = JUMP;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR:   next_state = (bus.Opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:    if (mem_ok) next_state = MEMWB;
      MEMWR:    if (mem_ok) next_state = FETCH;
      RTEXEC:   next_state = RTWB;
      ADDIEXEC: next_state = ADDIWB;
      MEMWB, RTWB, ADDIWB, BRANCH, JUMP: next_state = FETCH;
      default:  next_state = IDLE;
    endcase
  end

  // Unsupported opcodes are skipped (PC already advanced) but remembered until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      illegal_q <= 1'b0;
    else if (state == DECODE && !is_supported(bus.Opcode))
      illegal_q <= 1'b1;
  end

  control_output_decoder u_decoder (
    .state  (state),
    .mem_ok (mem_ok),
    .ctrl   (ctrl)
  );

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.IorD        = ctrl.i_or_d;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.dataUC      = ctrl.data_uc;
  assign bus.illegal_op  = illegal_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks each instruction class cycle
// by cycle against hand-written control words, plus a USE_MEM_READY=0 instance.
module tb_multicycle_control_unit;
  import control_pkg::*;

  // Word layout: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite ALUSrcA _ ALUSrcB _ PCSource _ dataUC
  localparam logic [16:0] W_IDLE      = 17'b0000000000_00_00_000;
  localparam logic [16:0] W_FETCH_GO  = 17'b1001010000_01_00_000;
  localparam logic [16:0] W_FETCH_WT  = 17'b0001000000_01_00_000;
  localparam logic [16:0] W_DECODE    = 17'b0000000000_11_00_000;
  localparam logic [16:0] W_ADREXEC   = 17'b0000000001_10_00_000;
  localparam logic [16:0] W_MEMRD     = 17'b0011000000_00_00_000;
  localparam logic [16:0] W_MEMWB     = 17'b0000001010_00_00_000;
  localparam logic [16:0] W_MEMWR     = 17'b0010100000_00_00_000;
  localparam logic [16:0] W_RTEXEC    = 17'b0000000001_00_00_010;
  localparam logic [16:0] W_RTWB      = 17'b0000000110_00_00_000;
  localparam logic [16:0] W_ADDIWB    = 17'b0000000010_00_00_000;
  localparam logic [16:0] W_BRANCH    = 17'b0100000001_00_01_001;
  localparam logic [16:0] W_JUMP      = 17'b1000000000_00_10_000;

  logic clk = 1'b0;
  logic rst_n, rst2_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  multicycle_control_unit_if bus1 ();
  multicycle_control_unit_if bus2 ();

  multicycle_control_unit #(.USE_MEM_READY(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  multicycle_control_unit #(.USE_MEM_READY(1'b0)) dut_nowait (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (bus2)
  );

  logic [16:0] word1, word2;
  assign word1 = {bus1.PCWrite, bus1.PCWriteCond, bus1.IorD, bus1.MemRead, bus1.MemWrite,
                  bus1.IRWrite, bus1.MemtoReg, bus1.RegDst, bus1.RegWrite, bus1.ALUSrcA,
                  bus1.ALUSrcB, bus1.PCSource, bus1.dataUC};
  assign word2 = {bus2.PCWrite, bus2.PCWriteCond, bus2.IorD, bus2.MemRead, bus2.MemWrite,
                  bus2.IRWrite, bus2.MemtoReg, bus2.RegDst, bus2.RegWrite, bus2.ALUSrcA,
                  bus2.ALUSrcB, bus2.PCSource, bus2.dataUC};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic ready);
    bus1.Opcode    = op;
    bus1.mem_ready = ready;
    bus2.Opcode    = op;
    bus2.mem_ready = ready;
  endtask

  // One clock: drive inputs at the falling edge, then check the state the last rising edge produced
  task automatic runCycle(input bit sel, input string tag, input logic [5:0] op, input logic ready,
                          input logic [16:0] exp_word, input state_t exp_state, input logic exp_ill);
    @(negedge clk);
    applyStimulus(op, ready);
    #1;
    if (sel == 1'b0) begin
      checkOutput({tag, "_word"}, 32'(word1), 32'(exp_word));
      checkOutput({tag, "_state"}, 32'(dut.state), 32'(exp_state));
      checkOutput({tag, "_illegal"}, 32'(bus1.illegal_op), 32'(exp_ill));
    end else begin
      checkOutput({tag, "_word"}, 32'(word2), 32'(exp_word));
      checkOutput({tag, "_state"}, 32'(dut_nowait.state), 32'(exp_state));
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    applyStimulus(OP_RTYPE, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_word", 32'(word1), 32'(W_IDLE));
    checkOutput("reset_illegal", 32'(bus1.illegal_op), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("idle_word", 32'(word1), 32'(W_IDLE));
    checkOutput("idle_state", 32'(dut.state), 32'(IDLE));

    // R-type add
    runCycle(0, "add_fetch",  OP_RTYPE, 1'b1, W_FETCH_GO, FETCH,  1'b0);
    runCycle(0, "add_decode", OP_RTYPE, 1'b1, W_DECODE,   DECODE, 1'b0);
    runCycle(0, "add_exec",   OP_RTYPE, 1'b1, W_RTEXEC,   RTEXEC, 1'b0);
    runCycle(0, "add_wb",     OP_RTYPE, 1'b1, W_RTWB,     RTWB,   1'b0);

    // lw with two fetch waits and one read wait
    runCycle(0, "lw_fetch_w1", OP_LW, 1'b0, W_FETCH_WT, FETCH,  1'b0);
    runCycle(0, "lw_fetch_w2", OP_LW, 1'b0, W_FETCH_WT, FETCH,  1'b0);
    runCycle(0, "lw_fetch",    OP_LW, 1'b1, W_FETCH_GO, FETCH,  1'b0);
    runCycle(0, "lw_decode",   OP_LW, 1'b1, W_DECODE,   DECODE, 1'b0);
    runCycle(0, "lw_memadr",   OP_LW, 1'b1, W_ADREXEC,  MEMADR, 1'b0);
    runCycle(0, "lw_memrd_w",  OP_LW, 1'b0, W_MEMRD,    MEMRD,  1'b0);
    runCycle(0, "lw_memrd",    OP_LW, 1'b1, W_MEMRD,    MEMRD,  1'b0);
    runCycle(0, "lw_memwb",    OP_LW, 1'b1, W_MEMWB,    MEMWB,  1'b0);

    // beq
    runCycle(0, "beq_fetch",  OP_BEQ, 1'b1, W_FETCH_GO, FETCH,  1'b0);
    runCycle(0, "beq_decode", OP_BEQ, 1'b1, W_DECODE,   DECODE, 1'b0);
    runCycle(0, "beq_branch", OP_BEQ, 1'b1, W_BRANCH,   BRANCH, 1'b0);

    // j then an unsupported opcode
    runCycle(0, "j_fetch",   OP_J, 1'b1, W_FETCH_GO, FETCH,  1'b0);
    runCycle(0, "j_decode",  OP_J, 1'b1, W_DECODE,   DECODE, 1'b0);
    runCycle(0, "j_jump",    OP_J, 1'b1, W_JUMP,     JUMP,   1'b0);
    runCycle(0, "ill_fetch",  6'b111111, 1'b1, W_FETCH_GO, FETCH,  1'b0);
    runCycle(0, "ill_decode", 6'b111111, 1'b1, W_DECODE,   DECODE, 1'b0);

    // sw with the sticky flag still set, reset asserted mid-write
    runCycle(0, "sw_fetch",   OP_SW, 1'b1, W_FETCH_GO, FETCH,  1'b1);
    runCycle(0, "sw_decode",  OP_SW, 1'b1, W_DECODE,   DECODE, 1'b1);
    runCycle(0, "sw_memadr",  OP_SW, 1'b1, W_ADREXEC,  MEMADR, 1'b1);
    runCycle(0, "sw_memwr_w", OP_SW, 1'b0, W_MEMWR,    MEMWR,  1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("sw_rst_memwrite", 32'(bus1.MemWrite), 32'd0);
    checkOutput("sw_rst_word", 32'(word1), 32'(W_IDLE));
    checkOutput("sw_rst_state", 32'(dut.state), 32'(IDLE));
    checkOutput("sw_rst_illegal", 32'(bus1.illegal_op), 32'd0);

    // mem_ready ignored: addi with mem_ready held low
    @(negedge clk);
    rst2_n = 1'b1;
    runCycle(1, "nw_fetch",  OP_ADDI, 1'b0, W_FETCH_GO, FETCH,    1'b0);
    runCycle(1, "nw_decode", OP_ADDI, 1'b0, W_DECODE,   DECODE,   1'b0);
    runCycle(1, "nw_exec",   OP_ADDI, 1'b0, W_ADREXEC,  ADDIEXEC, 1'b0);
    runCycle(1, "nw_wb",     OP_ADDI, 1'b0, W_ADDIWB,   ADDIWB,   1'b0);
    runCycle(1, "nw_next",   OP_ADDI, 1'b0, W_FETCH_GO, FETCH,    1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences the datapath through fetch, decode, execute, memory and writeback using the 6-bit opcode of the latched instruction.
- Drives all datapath enables and selects, plus the 3-bit dataUC code consumed by ALUControl.
- ALUControl is the downstream end; this block is the producer of its dataUC input.

Parameters:
- USE_MEM_READY, 1, when 1 the FETCH, MEMRD and MEMWR states stall until mem_ready=1; when 0 mem_ready is ignored and treated as 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- Opcode  input  6  instruction[31:26] from IR, valid from DECODE onward
- mem_ready  input  1  memory completes the current access this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load if ALU Zero (beq)
- IorD  output  1  memory address select: 0=PC, 1=ALUOut
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction register load
- MemtoReg  output  1  write-back data select: 0=ALUOut, 1=MDR
- RegDst  output  1  destination register select: 0=rt, 1=rd
- RegWrite  output  1  register file write enable
- ALUSrcA  output  1  ALU A select: 0=PC, 1=A register
- ALUSrcB  output  2  ALU B select: 00=B, 01=4, 10=sign-extended imm, 11=sign-extended imm<<2
- PCSource  output  2  PC source select: 00=ALU result, 01=ALUOut, 10=jump target
- dataUC  output  3  ALUOp code to ALUControl
- illegal_op  output  1  sticky flag set on an unsupported opcode

Behaviour:
- dataUC codes:
  - 000 = add
  - 001 = subtract
  - 010 = use funct field
  - 011 to 111 reserved, never driven
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXEC, RTWB, ADDIEXEC, ADDIWB, BRANCH, JUMP.
- Reset (rst_n=0, asynchronous): state=IDLE and illegal_op=0. In IDLE every output is 0.
- After rst_n rises, the first clock edge moves IDLE to FETCH. IDLE is never re-entered except via reset.
- Outputs are a Moore decode of state, except the mem_ready qualification below.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, dataUC=000, PCSource=00.
  - IRWrite and PCWrite equal mem_ready (Mealy gating).
  - Stays in FETCH while mem_ready=0; goes to DECODE on mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, dataUC=000 (branch target into ALUOut). Next state by Opcode:
  - lw/sw go to MEMADR.
  - R-type goes to RTEXEC.
  - addi goes to ADDIEXEC.
  - beq goes to BRANCH.
  - j goes to JUMP.
  - Any other opcode sets illegal_op=1 and goes to FETCH; the PC has already advanced, so the instruction is skipped.
- MEMADR: ALUSrcA=1, ALUSrcB=10, dataUC=000. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Goes to FETCH.
- MEMWR: MemWrite=1, IorD=1. Waits for mem_ready, then goes to FETCH. MemWrite stays high for every stall cycle.
- RTEXEC: ALUSrcA=1, ALUSrcB=00, dataUC=010. Goes to RTWB.
- RTWB: RegWrite=1, RegDst=1, MemtoReg=0. Goes to FETCH.
- ADDIEXEC: ALUSrcA=1, ALUSrcB=10, dataUC=000. Goes to ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, dataUC=001, PCWriteCond=1, PCSource=01. Goes to FETCH.
- JUMP: PCWrite=1, PCSource=10. Goes to FETCH.
- Cycle counts, zero-wait memory: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each memory wait cycle adds 1.
- Outputs not listed for a state are 0.
- illegal_op clears only on reset.
- Reset mid-instruction: everything returns to IDLE immediately and asynchronously; no partial RegWrite or MemWrite survives past the reset assertion.
- Opcode is sampled only in DECODE and MEMADR; changes in other states are ignored.

Decomposition:
- Shared package control_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI);
  - dataUC codes (ALUOP_ADD=000, ALUOP_SUB=001, ALUOP_FUNCT=010), used by both this block and ALUControl;
  - ALUSrcB and PCSource codes;
  - the state encoding.
- One sub-module, control_output_decoder: combinational map from state plus mem_ready to the control word. The top level keeps the state register, next-state logic and the illegal_op flag.

Test Plan:
- Reset then one add (Opcode=000000), mem_ready=1 -> IDLE, FETCH, DECODE, RTEXEC, RTWB; dataUC=010 in RTEXEC; RegWrite=1 and RegDst=1 only in RTWB.
- lw (100011) with mem_ready low for 2 cycles in FETCH and 1 in MEMRD -> 8 cycles FETCH to MEMWB; IRWrite and PCWrite high only on the mem_ready cycle; MemtoReg=1 in MEMWB.
- beq (000100) -> BRANCH shows dataUC=001, PCWriteCond=1, PCSource=01; FETCH follows at cycle 3.
- j (000010), then Opcode=111111 -> JUMP has PCWrite=1 and PCSource=10; the illegal opcode sets illegal_op=1, returns to FETCH, and the flag stays 1 over the next sw.
- sw (101011) with rst_n pulsed low during MEMWR -> MemWrite drops immediately, state=IDLE, illegal_op=0, all outputs 0.
- USE_MEM_READY=0 with mem_ready held 0 -> addi completes in 4 cycles with dataUC=000 in ADDIEXEC.
